// File: rtl/pnr_pkg.sv
// Shared types and default widths for the PNR trigger sequencer.
package pnr_pkg;

  localparam int PNR_DLY_W = 16;
  localparam int PNR_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } pnr_state_e;

endpackage

// File: rtl/pnr_edge_sync.sv
// Two-flop resynchroniser plus rising-edge detector for the external trigger.
// rise_o is high in the first cycle the synchronised level is 1 after being 0.
// A level that is already high when reset releases is not an edge: a low must
// be observed on a post-release sample before any rise is reported.
module pnr_edge_sync (
  input  logic ADC_CLK,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic s1, s2, prev;
  logic v1, v2;       // s1 / s2 hold a sample taken after reset release
  logic seen_low;     // a valid low has been seen since release

  // synchroniser chain, edge history and post-release qualification
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      s1       <= async_i;
      s2       <= s1;
      prev     <= s2;
      v1       <= 1'b1;
      v2       <= v1;
      seen_low <= seen_low | (v2 & ~s2);
    end
  end

  assign rise_o = s2 & ~prev & seen_low;

endmodule

// File: rtl/pnr_trigger_sequencer.sv
// PNR trigger sequencer: arms on arm_i, turns each accepted external edge into
// a trigger_o clear pulse followed D cycles later by a delayed_trigger_o sample
// pulse, then a holdoff window, until the shot limit is reached or stop_i.
// Optional feature: define PNR_SEQ_MISSED_CNT_EN to build the missed-edge
// counter; otherwise missed_cnt_o is tied to zero.
module pnr_trigger_sequencer
  import pnr_pkg::*;
#(
  parameter int DLY_W = PNR_DLY_W,
  parameter int CNT_W = PNR_CNT_W
) (
  input  logic             ADC_CLK,
  input  logic             rst_i,
  input  logic             ext_trig_i,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic [DLY_W-1:0] trig_delay_i,
  input  logic [DLY_W-1:0] holdoff_i,
  input  logic [CNT_W-1:0] shot_limit_i,
  input  logic             fifo_full_i,
  output logic             trigger_o,
  output logic             delayed_trigger_o,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] shot_cnt_o,
  output logic [CNT_W-1:0] missed_cnt_o
);

  pnr_state_e       state, state_nxt;
  logic [DLY_W-1:0] cnt, cnt_nxt;          // shared delay / holdoff down-counter
  logic [DLY_W-1:0] hold_lat, hold_lat_nxt;
  logic [CNT_W-1:0] shot_nxt, shot_inc;
  logic             trig_nxt, dtrig_nxt;
  logic             trig_rise;

  pnr_edge_sync u_sync (
    .ADC_CLK (ADC_CLK),
    .rst_i   (rst_i),
    .async_i (ext_trig_i),
    .rise_o  (trig_rise)
  );

  assign shot_inc = (&shot_cnt_o) ? shot_cnt_o : shot_cnt_o + 1'b1;

  // next-state, counter and pulse decode
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_lat_nxt = hold_lat;
    shot_nxt     = shot_cnt_o;
    trig_nxt     = 1'b0;
    dtrig_nxt    = 1'b0;
    if (stop_i) begin
      // abort wins over everything, including a same-cycle arm
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_nxt = ST_ARMED;
            shot_nxt  = '0;
          end
        end
        ST_ARMED: begin
          if (trig_rise && !fifo_full_i) begin
            trig_nxt     = 1'b1;
            state_nxt    = ST_DELAY;
            // delay of 0 behaves as 1; counter reaches 0 in the cycle before the sample
            cnt_nxt      = (trig_delay_i == '0) ? '0 : trig_delay_i - 1'b1;
            hold_lat_nxt = holdoff_i;
          end
        end
        ST_DELAY: begin
          if (cnt == '0) begin
            dtrig_nxt = 1'b1;
            shot_nxt  = shot_inc;
            if (hold_lat == '0) begin
              state_nxt = (shot_limit_i != '0 && shot_inc == shot_limit_i) ? ST_DONE : ST_ARMED;
            end else begin
              state_nxt = ST_HOLDOFF;
              cnt_nxt   = hold_lat - 1'b1;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state_nxt = (shot_limit_i != '0 && shot_cnt_o == shot_limit_i) ? ST_DONE : ST_ARMED;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // state, shot counter and registered outputs
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      hold_lat          <= '0;
      shot_cnt_o        <= '0;
      trigger_o         <= 1'b0;
      delayed_trigger_o <= 1'b0;
      armed_o           <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      hold_lat          <= hold_lat_nxt;
      shot_cnt_o        <= shot_nxt;
      trigger_o         <= trig_nxt;
      delayed_trigger_o <= dtrig_nxt;
      armed_o           <= (state_nxt == ST_ARMED);
      busy_o            <= (state_nxt == ST_DELAY) || (state_nxt == ST_HOLDOFF);
      done_o            <= (state_nxt == ST_DONE);
    end
  end

`ifdef PNR_SEQ_MISSED_CNT_EN
  logic miss_clr, miss_inc;

  // an edge is missed when the FIFO is full in ARMED or a shot is in flight
  always_comb begin
    miss_clr = !stop_i && arm_i && (state == ST_IDLE || state == ST_DONE);
    miss_inc = !stop_i && trig_rise &&
               ((state == ST_ARMED && fifo_full_i) ||
                state == ST_DELAY || state == ST_HOLDOFF);
  end

  // saturating missed-edge counter, cleared on arm
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i)                          missed_cnt_o <= '0;
    else if (miss_clr)                  missed_cnt_o <= '0;
    else if (miss_inc && !(&missed_cnt_o)) missed_cnt_o <= missed_cnt_o + 1'b1;
  end
`else
  assign missed_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pnr_trigger_sequencer.sv
// Directed bench: stimulus pushes expected pulse times into a scoreboard queue,
// a negedge monitor pops and compares every trigger/delayed pulse.
module tb_pnr_trigger_sequencer;
  localparam int DW = 16;
  localparam int CW = 32;

`ifdef PNR_SEQ_MISSED_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic          ADC_CLK = 1'b0;
  logic          rst_i = 1'b1;
  logic          ext_trig_i = 1'b0, arm_i = 1'b0, stop_i = 1'b0, fifo_full_i = 1'b0;
  logic [DW-1:0] trig_delay_i = '0, holdoff_i = '0;
  logic [CW-1:0] shot_limit_i = '0;
  logic          trigger_o, delayed_trigger_o, armed_o, busy_o, done_o;
  logic [CW-1:0] shot_cnt_o, missed_cnt_o;

  pnr_trigger_sequencer #(.DLY_W(DW), .CNT_W(CW)) dut (
    .ADC_CLK           (ADC_CLK),
    .rst_i             (rst_i),
    .ext_trig_i        (ext_trig_i),
    .arm_i             (arm_i),
    .stop_i            (stop_i),
    .trig_delay_i      (trig_delay_i),
    .holdoff_i         (holdoff_i),
    .shot_limit_i      (shot_limit_i),
    .fifo_full_i       (fifo_full_i),
    .trigger_o         (trigger_o),
    .delayed_trigger_o (delayed_trigger_o),
    .armed_o           (armed_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .shot_cnt_o        (shot_cnt_o),
    .missed_cnt_o      (missed_cnt_o)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  int cyc = 0;
  always @(posedge ADC_CLK) cyc <= cyc + 1;

  typedef struct { int kind; int at; } ev_t;  // kind 0 = trigger_o, 1 = delayed_trigger_o
  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic int mexp(int n);
    return MISS_EN ? n : 0;
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge ADC_CLK);
      #1;
    end
  endtask

  task automatic wait_until(int t);
    while (cyc < t) tick(1);
  endtask

  // one-cycle external pulse raised now; edge cycle E = now+2, trigger at E+1
  task automatic fire(int d, bit want_dly);
    int n;
    ev_t e;
    n = cyc;
    ext_trig_i = 1'b1;
    e.kind = 0; e.at = n + 3;
    exp_q.push_back(e);
    if (want_dly) begin
      e.kind = 1; e.at = n + 3 + ((d == 0) ? 1 : d);
      exp_q.push_back(e);
    end
    tick(1);
    ext_trig_i = 1'b0;
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1;
    tick(1);
    arm_i = 1'b0;
  endtask

  task automatic mon_pop(int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL pulse: unexpected kind %0d at cycle %0d, none required", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        errors++;
        $display("FAIL pulse: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.at);
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge ADC_CLK) begin
    if (trigger_o && delayed_trigger_o) begin
      checks++;
      errors++;
      $display("FAIL coincident: trigger and delayed both 1 at cycle %0d, want never", cyc);
    end
    if (trigger_o)         mon_pop(0);
    if (delayed_trigger_o) mon_pop(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // reset state
    tick(3);
    chk("rst trigger", trigger_o, 0);
    chk("rst armed", armed_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst shot", shot_cnt_o, 0);
    chk("rst missed", missed_cnt_o, 0);
    rst_i = 1'b0;
    tick(2);

    // two shots, delay 5, holdoff 3, limit 2
    trig_delay_i = 5; holdoff_i = 3; shot_limit_i = 2;
    pulse_arm();
    chk("t1 armed", armed_o, 1);
    n = cyc;
    fire(5, 1'b1);
    wait_until(n + 5);
    chk("t1 busy in delay", busy_o, 1);
    wait_until(n + 20);
    fire(5, 1'b1);
    wait_until(n + 36);
    chk("t1 shot", shot_cnt_o, 2);
    chk("t1 done", done_o, 1);
    chk("t1 busy", busy_o, 0);
    chk("t1 missed", missed_cnt_o, 0);

    // zero delay behaves as one; limit 1 ends in DONE
    trig_delay_i = 0; holdoff_i = 0; shot_limit_i = 1;
    pulse_arm();
    chk("t2 shot cleared", shot_cnt_o, 0);
    chk("t2 armed", armed_o, 1);
    tick(2);
    n = cyc;
    fire(0, 1'b1);
    wait_until(n + 8);
    chk("t2 done", done_o, 1);
    chk("t2 shot", shot_cnt_o, 1);

    // second edge during DELAY is dropped
    trig_delay_i = 10; holdoff_i = 0; shot_limit_i = 0;
    pulse_arm();
    tick(2);
    n = cyc;
    fire(10, 1'b1);
    tick(1);
    ext_trig_i = 1'b1;
    tick(1);
    ext_trig_i = 1'b0;
    wait_until(n + 20);
    chk("t3 missed", missed_cnt_o, mexp(1));
    chk("t3 shot", shot_cnt_o, 1);
    chk("t3 armed", armed_o, 1);

    // FIFO full rejects the edge, next edge accepted
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    chk("t4 idle", armed_o, 0);
    pulse_arm();
    chk("t4 shot cleared", shot_cnt_o, 0);
    chk("t4 missed cleared", missed_cnt_o, 0);
    trig_delay_i = 2;
    fifo_full_i = 1'b1;
    n = cyc;
    ext_trig_i = 1'b1;
    tick(1);
    ext_trig_i = 1'b0;
    wait_until(n + 6);
    fifo_full_i = 1'b0;
    chk("t4 still armed", armed_o, 1);
    chk("t4 not busy", busy_o, 0);
    chk("t4 missed", missed_cnt_o, mexp(1));
    tick(2);
    fire(2, 1'b1);
    tick(8);
    chk("t4 shot", shot_cnt_o, 1);

    // stop cancels the pending sample; stop beats arm
    trig_delay_i = 8;
    n = cyc;
    fire(8, 1'b0);
    wait_until(n + 6);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    tick(1);
    chk("t5 armed", armed_o, 0);
    chk("t5 busy", busy_o, 0);
    chk("t5 done", done_o, 0);
    wait_until(n + 16);
    chk("t5 shot held", shot_cnt_o, 1);
    chk("t5 missed held", missed_cnt_o, mexp(1));
    arm_i = 1'b1; stop_i = 1'b1;
    tick(1);
    arm_i = 1'b0; stop_i = 1'b0;
    chk("t5 arm+stop idle", armed_o, 0);
    tick(1);
    chk("t5 arm+stop shot", shot_cnt_o, 1);

    // build counters to 7, reset mid-holdoff with trigger held high
    trig_delay_i = 1; holdoff_i = 10; shot_limit_i = 0;
    pulse_arm();
    tick(2);
    for (int i = 0; i < 7; i++) begin
      n = cyc;
      fire(1, 1'b1);
      wait_until(n + 4);
      ext_trig_i = 1'b1;
      tick(1);
      ext_trig_i = 1'b0;
      if (i < 6) wait_until(n + 16);
    end
    wait_until(n + 9);
    chk("t6 shot 7", shot_cnt_o, 7);
    chk("t6 missed 7", missed_cnt_o, mexp(7));
    chk("t6 busy", busy_o, 1);
    rst_i = 1'b1;
    ext_trig_i = 1'b1;
    #1;
    chk("t6 rst shot", shot_cnt_o, 0);
    chk("t6 rst missed", missed_cnt_o, 0);
    chk("t6 rst busy", busy_o, 0);
    chk("t6 rst armed", armed_o, 0);
    chk("t6 rst delayed", delayed_trigger_o, 0);
    tick(3);
    rst_i = 1'b0;
    trig_delay_i = 1; holdoff_i = 0;
    tick(1);
    pulse_arm();
    tick(8);
    chk("t6 held high armed", armed_o, 1);
    chk("t6 held high shot", shot_cnt_o, 0);
    ext_trig_i = 1'b0;
    tick(3);
    fire(1, 1'b1);
    tick(6);
    chk("t6 new edge shot", shot_cnt_o, 1);

    tick(4);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
